flag_event_sender: RTL and testbench

FLAG_EVENT_SENDER -- requirements
Module: flag_event_sender

---
 rtl/flag_event_sender.sv | 135 +++++++++++++
 tb/tb_flag_event_sender.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_event_sender.sv
// Event-to-flag sender: queues single-cycle event requests and issues one flag
// pulse per event, waiting for the flag crossing's Busy rise/fall handshake.
//
// state     | meaning
// IDLE      | no handshake in flight; issues when events are queued and Busy is low
// ISSUE     | FlagIn_clkA high for exactly one cycle
// WAIT_BUSY | waiting for Busy_clkA to rise
// WAIT_ACK  | waiting for Busy_clkA to fall
module flag_event_sender #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic             clkA,
  input  logic             rstA_n,
  input  logic             EventIn_clkA,
  input  logic             Busy_clkA,
  input  logic             ClearErr_clkA,
  output logic             FlagIn_clkA,
  output logic [CNT_W-1:0] Pending_clkA,
  output logic             Overflow_clkA,
  output logic             Timeout_clkA,
  output logic             Idle_clkA
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_ACK  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d, to_cnt_inc;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic             flag_q, flag_d;
  logic             idle_q, idle_d;
  logic             issue;
  logic             ovf_set;
  logic             tmo_set;

  assign issue      = (state_q == IDLE) && (pend_q != '0) && !Busy_clkA;
  assign to_cnt_inc = to_cnt_q + 1'b1;

  // Timeout is checked before handshake progress so the wait never exceeds TIMEOUT cycles.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    tmo_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d  = ISSUE;
          to_cnt_d = '0;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        to_cnt_d = to_cnt_inc;
        if (to_cnt_inc == TO_LIMIT) begin
          state_d = IDLE;
          tmo_set = 1'b1;
        end else if (Busy_clkA) begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        to_cnt_d = to_cnt_inc;
        if (to_cnt_inc == TO_LIMIT) begin
          state_d = IDLE;
          tmo_set = 1'b1;
        end else if (!Busy_clkA) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A simultaneous event and issue cancel out; a full counter drops the event.
  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (EventIn_clkA && !issue) begin
      if (pend_q == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (!EventIn_clkA && issue) begin
      pend_d = pend_q - 1'b1;
    end
  end

  assign ovf_d  = ovf_set | (ovf_q & ~ClearErr_clkA);
  assign tmo_d  = tmo_set | (tmo_q & ~ClearErr_clkA);
  assign flag_d = (state_d == ISSUE);
  assign idle_d = (state_d == IDLE) && (pend_d == '0);

  always_ff @(posedge clkA or negedge rstA_n) begin
    if (!rstA_n) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      to_cnt_q <= '0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
      flag_q   <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      to_cnt_q <= to_cnt_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
      flag_q   <= flag_d;
      idle_q   <= idle_d;
    end
  end

  assign FlagIn_clkA   = flag_q;
  assign Pending_clkA  = pend_q;
  assign Overflow_clkA = ovf_q;
  assign Timeout_clkA  = tmo_q;
  assign Idle_clkA     = idle_q;

endmodule

// File: tb/tb_flag_event_sender.sv
// Directed bench for flag_event_sender (CNT_W=4, TIMEOUT=8) with an optional
// Busy responder that raises Busy one cycle after FlagIn and drops it six cycles later.
module tb_flag_event_sender;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 8;
  localparam int TO_W    = 10;

  logic             clkA          = 1'b0;
  logic             rstA_n        = 1'b0;
  logic             EventIn_clkA  = 1'b0;
  logic             ClearErr_clkA = 1'b0;
  logic             busy_man      = 1'b0;
  logic             busy_auto     = 1'b0;
  logic             auto_on       = 1'b0;
  logic             Busy_clkA;
  logic             FlagIn_clkA;
  logic [CNT_W-1:0] Pending_clkA;
  logic             Overflow_clkA;
  logic             Timeout_clkA;
  logic             Idle_clkA;

  int checks = 0;
  int errors = 0;

  assign Busy_clkA = auto_on ? busy_auto : busy_man;

  flag_event_sender #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clkA          (clkA),
    .rstA_n        (rstA_n),
    .EventIn_clkA  (EventIn_clkA),
    .Busy_clkA     (Busy_clkA),
    .ClearErr_clkA (ClearErr_clkA),
    .FlagIn_clkA   (FlagIn_clkA),
    .Pending_clkA  (Pending_clkA),
    .Overflow_clkA (Overflow_clkA),
    .Timeout_clkA  (Timeout_clkA),
    .Idle_clkA     (Idle_clkA)
  );

  always #5 clkA = ~clkA;

  // Busy responder works on the falling edge so it never races the checks.
  initial begin
    int rcnt;
    rcnt = 0;
    forever begin
      @(negedge clkA);
      if (!auto_on) begin
        rcnt      = 0;
        busy_auto = 1'b0;
      end else if (FlagIn_clkA === 1'b1) begin
        rcnt = 1;
      end else if (rcnt != 0) begin
        rcnt++;
        if (rcnt == 2) busy_auto = 1'b1;
        if (rcnt == 8) begin
          busy_auto = 1'b0;
          rcnt      = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clkA);
    #1;
  endtask

  task automatic test_reset();
    rstA_n = 1'b0;
    tick();
    checks++; if (FlagIn_clkA !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b expected 0", FlagIn_clkA); end
    checks++; if (Pending_clkA !== 4'd0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", Pending_clkA); end
    checks++; if (Overflow_clkA !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", Overflow_clkA); end
    checks++; if (Timeout_clkA !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", Timeout_clkA); end
    checks++; if (Idle_clkA !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", Idle_clkA); end
    rstA_n = 1'b1;
    tick();
    checks++; if (Idle_clkA !== 1'b1 || FlagIn_clkA !== 1'b0) begin errors++; $display("FAIL post_release: idle %b flag %b expected 1 0", Idle_clkA, FlagIn_clkA); end
  endtask

  task automatic test_single();
    int pulses;
    auto_on      = 1'b1;
    EventIn_clkA = 1'b1;
    tick();
    EventIn_clkA = 1'b0;
    checks++; if (Pending_clkA !== 4'd1 || FlagIn_clkA !== 1'b0) begin errors++; $display("FAIL single_queued: pending %0d flag %b expected 1 0", Pending_clkA, FlagIn_clkA); end
    tick();
    checks++; if (FlagIn_clkA !== 1'b1) begin errors++; $display("FAIL single_latency: flag %b expected 1", FlagIn_clkA); end
    checks++; if (Pending_clkA !== 4'd0) begin errors++; $display("FAIL single_decrement: pending %0d expected 0", Pending_clkA); end
    pulses = (FlagIn_clkA === 1'b1) ? 1 : 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (FlagIn_clkA === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulse_count: got %0d expected 1", pulses); end
    checks++; if (Idle_clkA !== 1'b1 || Pending_clkA !== 4'd0) begin errors++; $display("FAIL single_idle: idle %b pending %0d expected 1 0", Idle_clkA, Pending_clkA); end
    checks++; if (Timeout_clkA !== 1'b0) begin errors++; $display("FAIL single_no_timeout: got %b expected 0", Timeout_clkA); end
    auto_on = 1'b0;
  endtask

  task automatic test_back_to_back();
    int pulses, peak;
    logic seen_high, fell;
    pulses = 0; peak = 0; seen_high = 1'b0; fell = 1'b0;
    auto_on = 1'b1;
    for (int c = 0; c < 40; c++) begin
      EventIn_clkA = (c < 3);
      tick();
      if (int'(Pending_clkA) > peak) peak = int'(Pending_clkA);
      if (FlagIn_clkA === 1'b1) begin
        pulses++;
        checks++;
        if (Busy_clkA !== 1'b0 || (pulses > 1 && !fell)) begin
          errors++; $display("FAIL b2b_issue_gap: pulse %0d busy %b busy_cycle_done %b expected 0 1", pulses, Busy_clkA, fell);
        end
        seen_high = 1'b0; fell = 1'b0;
      end else if (Busy_clkA === 1'b1) begin
        seen_high = 1'b1;
      end else if (seen_high) begin
        fell = 1'b1;
      end
    end
    EventIn_clkA = 1'b0;
    checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulse_count: got %0d expected 3", pulses); end
    checks++; if (peak != 2) begin errors++; $display("FAIL b2b_pending_peak: got %0d expected 2", peak); end
    checks++; if (Idle_clkA !== 1'b1 || Pending_clkA !== 4'd0) begin errors++; $display("FAIL b2b_idle: idle %b pending %0d expected 1 0", Idle_clkA, Pending_clkA); end
    auto_on = 1'b0;
  endtask

  task automatic test_timeout();
    int pulses;
    busy_man     = 1'b0;
    EventIn_clkA = 1'b1;
    tick();
    EventIn_clkA = 1'b0;
    tick();
    checks++; if (FlagIn_clkA !== 1'b1) begin errors++; $display("FAIL to_issue: flag %b expected 1", FlagIn_clkA); end
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (FlagIn_clkA === 1'b1) pulses++;
    end
    checks++; if (Timeout_clkA !== 1'b0 || Idle_clkA !== 1'b0) begin errors++; $display("FAIL to_early: timeout %b idle %b expected 0 0", Timeout_clkA, Idle_clkA); end
    tick();
    if (FlagIn_clkA === 1'b1) pulses++;
    checks++; if (Timeout_clkA !== 1'b1) begin errors++; $display("FAIL to_set: timeout %b expected 1", Timeout_clkA); end
    checks++; if (Idle_clkA !== 1'b1 || Pending_clkA !== 4'd0) begin errors++; $display("FAIL to_back_idle: idle %b pending %0d expected 1 0", Idle_clkA, Pending_clkA); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL to_no_reissue: pulses %0d expected 0", pulses); end
    ClearErr_clkA = 1'b1;
    tick();
    ClearErr_clkA = 1'b0;
    checks++; if (Timeout_clkA !== 1'b0) begin errors++; $display("FAIL to_clear: timeout %b expected 0", Timeout_clkA); end
  endtask

  task automatic test_stale_busy();
    int pulses;
    busy_man     = 1'b1;
    EventIn_clkA = 1'b1;
    tick();
    EventIn_clkA = 1'b0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (FlagIn_clkA === 1'b1) pulses++;
    end
    checks++; if (pulses != 0 || Pending_clkA !== 4'd1) begin errors++; $display("FAIL stale_hold: pulses %0d pending %0d expected 0 1", pulses, Pending_clkA); end
    busy_man = 1'b0;
    tick();
    checks++; if (FlagIn_clkA !== 1'b1 || Pending_clkA !== 4'd0) begin errors++; $display("FAIL stale_release: flag %b pending %0d expected 1 0", FlagIn_clkA, Pending_clkA); end
    tick();
    busy_man = 1'b1;
    tick();
    busy_man = 1'b0;
    tick();
    checks++; if (Idle_clkA !== 1'b1 || Timeout_clkA !== 1'b0) begin errors++; $display("FAIL stale_done: idle %b timeout %b expected 1 0", Idle_clkA, Timeout_clkA); end
  endtask

  task automatic test_overflow();
    int pulses;
    pulses   = 0;
    busy_man = 1'b1;
    EventIn_clkA = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (FlagIn_clkA === 1'b1) pulses++;
    end
    checks++; if (Pending_clkA !== 4'd15 || Overflow_clkA !== 1'b0) begin errors++; $display("FAIL ovf_fill: pending %0d ovf %b expected 15 0", Pending_clkA, Overflow_clkA); end
    tick();
    checks++; if (Pending_clkA !== 4'd15 || Overflow_clkA !== 1'b1) begin errors++; $display("FAIL ovf_16th: pending %0d ovf %b expected 15 1", Pending_clkA, Overflow_clkA); end
    tick();
    checks++; if (Pending_clkA !== 4'd15 || Overflow_clkA !== 1'b1) begin errors++; $display("FAIL ovf_17th: pending %0d ovf %b expected 15 1", Pending_clkA, Overflow_clkA); end
    ClearErr_clkA = 1'b1;
    tick();
    checks++; if (Overflow_clkA !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: ovf %b expected 1", Overflow_clkA); end
    EventIn_clkA = 1'b0;
    tick();
    ClearErr_clkA = 1'b0;
    checks++; if (Overflow_clkA !== 1'b0 || Pending_clkA !== 4'd15) begin errors++; $display("FAIL ovf_clear: ovf %b pending %0d expected 0 15", Overflow_clkA, Pending_clkA); end
    checks++; if (pulses != 0 || FlagIn_clkA !== 1'b0) begin errors++; $display("FAIL ovf_no_flag_busy: pulses %0d flag %b expected 0 0", pulses, FlagIn_clkA); end
    busy_man = 1'b0;
    #2 rstA_n = 1'b0;
    #2 rstA_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int pulses;
    busy_man = 1'b0;
    EventIn_clkA = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    EventIn_clkA = 1'b0;
    busy_man     = 1'b1;
    tick();
    checks++; if (Pending_clkA !== 4'd3 || Idle_clkA !== 1'b0 || FlagIn_clkA !== 1'b0) begin errors++; $display("FAIL mid_setup: pending %0d idle %b flag %b expected 3 0 0", Pending_clkA, Idle_clkA, FlagIn_clkA); end
    #3 rstA_n = 1'b0;
    #1;
    checks++; if (Pending_clkA !== 4'd0 || Idle_clkA !== 1'b1) begin errors++; $display("FAIL mid_async_pending_idle: pending %0d idle %b expected 0 1", Pending_clkA, Idle_clkA); end
    checks++; if (FlagIn_clkA !== 1'b0 || Overflow_clkA !== 1'b0 || Timeout_clkA !== 1'b0) begin errors++; $display("FAIL mid_async_flags: flag %b ovf %b tmo %b expected 0 0 0", FlagIn_clkA, Overflow_clkA, Timeout_clkA); end
    busy_man = 1'b0;
    #2 rstA_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (FlagIn_clkA === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL mid_no_flag_after: pulses %0d expected 0", pulses); end
    checks++; if (Idle_clkA !== 1'b1 || Pending_clkA !== 4'd0) begin errors++; $display("FAIL mid_idle_after: idle %b pending %0d expected 1 0", Idle_clkA, Pending_clkA); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_stale_busy();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
